// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional feature macro used by the users of this package: NIBBLE_ADDER_OVF_EN.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Number of nibble cycles needed to cover a WIDTH-bit operand.
  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// NIBBLE_ADDER_OVF_EN adds the signed-overflow flag to the result side.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef NIBBLE_ADDER_OVF_EN
  logic             ovf;
`endif

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
`ifdef NIBBLE_ADDER_OVF_EN
    , input ovf
`endif
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
`ifdef NIBBLE_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/nibble_add.sv
// Combinational 4-bit adder with carry in/out.
// With NIBBLE_ADDER_OVF_EN it also exposes the carry into bit 3 so the
// caller can form the signed overflow of the most significant nibble.
module nibble_add (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
`ifdef NIBBLE_ADDER_OVF_EN
  , output logic     o_msb_cin
`endif
);

  logic [3:0] w_low;
  logic [1:0] w_high;

  // Split at bit 3 so the carry into the top bit is available as a tap.
  always_comb begin
    w_low  = {1'b0, i_a[2:0]} + {1'b0, i_b[2:0]} + {3'b000, i_cin};
    w_high = {1'b0, i_a[3]} + {1'b0, i_b[3]} + {1'b0, w_low[3]};
  end

  assign o_sum  = {w_high[0], w_low[2:0]};
  assign o_cout = w_high[1];
`ifdef NIBBLE_ADDER_OVF_EN
  assign o_msb_cin = w_low[3];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder computing a + b + cin one nibble per clock, LSB first,
// with valid/ready handshakes on both sides.
// Optional: NIBBLE_ADDER_OVF_EN adds a registered signed-overflow flag.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding nibble r_idx, carry held in r_carry
// DONE  | result presented with out_valid=1 until out_ready
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [IDX_W-1:0]   r_idx;

  logic               w_accept;
  logic               w_last;
  logic [NIB_W-1:0]   w_nib_a;
  logic [NIB_W-1:0]   w_nib_b;
  logic [NIB_W-1:0]   w_nib_sum;
  logic               w_nib_cout;
`ifdef NIBBLE_ADDER_OVF_EN
  logic               w_msb_cin;
  logic               r_ovf;
`endif

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_last   = (r_idx == IDX_W'(NIB - 1));
  assign w_nib_a  = r_a[NIB_W*r_idx +: NIB_W];
  assign w_nib_b  = r_b[NIB_W*r_idx +: NIB_W];

  nibble_add u_nibble_add (
    .i_a      (w_nib_a),
    .i_b      (w_nib_b),
    .i_cin    (r_carry),
    .o_sum    (w_nib_sum),
    .o_cout   (w_nib_cout)
`ifdef NIBBLE_ADDER_OVF_EN
    , .o_msb_cin(w_msb_cin)
`endif
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; out_ready outside DONE is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture at accept, then one nibble of sum per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
`ifdef NIBBLE_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[NIB_W*r_idx +: NIB_W] <= w_nib_sum;
      r_carry <= w_nib_cout;
      if (w_last) begin
        r_cout <= w_nib_cout;
`ifdef NIBBLE_ADDER_OVF_EN
        r_ovf  <= w_msb_cin ^ w_nib_cout;
`endif
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
`ifdef NIBBLE_ADDER_OVF_EN
  assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16). Checks the ovf flag
// as well when NIBBLE_ADDER_OVF_EN is defined.
module tb_nibble_serial_adder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  nibble_serial_adder_if #(.WIDTH(16)) bus ();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        scr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(bus.in_ready), 1);
    bus.a        = v.a;
    bus.b        = v.b;
    bus.cin      = v.cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, " in_ready busy"}, 32'(bus.in_ready), 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (v.scr) begin
        bus.a   = 16'($urandom);
        bus.b   = 16'($urandom);
        bus.cin = 1'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 32'(lat), 4);
    chk({tag, " sum"}, 32'(bus.sum), 32'(v.s));
    chk({tag, " cout"}, 32'(bus.cout), 32'(v.co));
`ifdef NIBBLE_ADDER_OVF_EN
    chk({tag, " ovf"}, 32'(bus.ovf), 32'(v.ov));
`endif
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 32'(bus.out_valid), 0);
    chk({tag, " sum retained"}, 32'(bus.sum), 32'(v.s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    n_checks = 0;
    n_fail   = 0;
    //           a        b        cin   sum      co    ov    scramble
    vecs[0] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    rst_n         = 1'b0;
    #12;
    chk("reset in_ready", 32'(bus.in_ready), 1);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset sum", 32'(bus.sum), 0);
    chk("reset cout", 32'(bus.cout), 0);
`ifdef NIBBLE_ADDER_OVF_EN
    chk("reset ovf", 32'(bus.ovf), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // out_ready while idle must not disturb anything
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("idle out_ready in_ready", 32'(bus.in_ready), 1);
    chk("idle out_ready out_valid", 32'(bus.out_valid), 0);

    for (int i = 0; i < 10; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held for 5 cycles, extra in_valid ignored
    @(negedge clk);
    bus.a = 16'h0006; bus.b = 16'h0001; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp out_valid rise", 32'(bus.out_valid), 1);
    bus.a = 16'hAAAA; bus.b = 16'h1111; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d out_valid", k), 32'(bus.out_valid), 1);
      chk($sformatf("bp hold%0d sum", k), 32'(bus.sum), 32'h0007);
      chk($sformatf("bp hold%0d in_ready", k), 32'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp release in_ready", 32'(bus.in_ready), 1);
    chk("bp release out_valid", 32'(bus.out_valid), 0);
    chk("bp release sum", 32'(bus.sum), 32'h0007);

    // Reset pulse during RUN cycle 2 discards the operation
    @(negedge clk);
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst busy before", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst async in_ready", 32'(bus.in_ready), 1);
    chk("rst async busy", 32'(bus.busy), 0);
    chk("rst async out_valid", 32'(bus.out_valid), 0);
    chk("rst async sum", 32'(bus.sum), 0);
    chk("rst async cout", 32'(bus.cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rst no out_valid %0d", k), 32'(bus.out_valid), 0);
    end
    v = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    do_op(v, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder that computes a + b + cin one 4-bit nibble per clock, LSB nibble first.
- The nibble carry is held in a register between cycles.
- Sits directly upstream of the result consumer and feeds it through a valid/ready handshake.
- The input side uses a matching valid/ready handshake.
- Trades latency for a single 4-bit add datapath.

Parameters:
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 and ≥ 4.
- NIB, WIDTH/4 (localparam): number of nibble cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b/cin present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to the LSB nibble.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry out of the MSB nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; cout=0; internal operand registers, carry and nibble index=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b; carry<=cin; idx<=0; state→RUN.
- RUN:
  - Each cycle, add nibble idx of a, nibble idx of b, and carry.
  - Write the 4-bit result into sum[4*idx+:4]; carry<=nibble carry-out.
  - If idx==NIB-1: cout<=nibble carry-out, state→DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: state→IDLE.
- Latency: out_valid rises exactly NIB rising edges after the accepting edge (4 for WIDTH=16).
- Throughput: at most one operation per NIB+2 cycles. No overlap; in_ready=0 whenever busy.
- Handshake rules:
  - Input operands are sampled only at the accept edge; later changes to a/b/cin are ignored.
  - in_valid while busy is ignored and not queued.
  - out_valid, once high, stays high with unchanged data until out_ready is seen.
  - out_ready while not out_valid has no effect.
- sum/cout after the DONE→IDLE transition retain the last result. They are valid only while out_valid=1.
- Arithmetic:
  - Unsigned; sum wraps modulo 2^WIDTH.
  - cout is the true carry of the full-width add, including a carry generated by cin alone (e.g. all-ones + 0 + 1).
- rst_n asserted mid-RUN or in DONE: immediate return to reset values. The in-flight operation is discarded and no out_valid is produced.

Optional Feature:
NIBBLE_ADDER_OVF_EN
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - Set in the final RUN cycle to the signed two's-complement overflow of the full add: carry into MSB XOR carry out of MSB.
  - Held with sum and valid under out_valid.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package nibble_add_pkg:
  - state enum typedef (IDLE/RUN/DONE).
  - NIB_W=4 constant.
  - function computing NIB from WIDTH.
- Sub-module nibble_add:
  - Purely combinational 4-bit + carry-in → 4-bit sum + carry-out (plus MSB carry-in tap for the ovf feature).
  - Instantiated once in the datapath.
- FSM, index counter and registers live in nibble_serial_adder.

Test Plan:
- WIDTH=16: a=0x5555, b=0xAAAA, cin=0, out_ready=1 → out_valid exactly 4 edges after accept; sum=0xFFFF, cout=0.
- a=0x0000, b=0xFFFF, cin=1 → sum=0x0000, cout=1. The carry ripples through all 4 nibble cycles.
- a=0x0006, b=0x0001, cin=0 with out_ready held 0 for 5 cycles → out_valid stays 1 and sum=0x0007 stable. in_ready=0 throughout; a second in_valid during this window is not accepted. Result taken when out_ready=1; in_ready returns next cycle.
- Change a/b every cycle during RUN after accepting a=0x1234, b=0x1111 → sum=0x2345, unaffected by the changes.
- rst_n pulsed low in RUN cycle 2 → outputs return to reset values asynchronously; no out_valid appears. Next operation a=0xFFFF, b=0x0001 → sum=0x0000, cout=1.
- With NIBBLE_ADDER_OVF_EN: 0x7FFF+0x0001 → ovf=1, cout=0. 0xFFFF+0x0001 → ovf=0, cout=1.
